stopwatch_tick_counter: RTL and testbench

Consumes the divided slow clock (clk_out of clk_divider) as a plain data input. It synchronises that input into the system clock domain and turns each rising edge into a single-cycle tick. Each tick drives a DIGITS-wide BCD up/down counter, gated by a start/pause/clear FSM. Output count feeds the seven-segment display path.

---
 rtl/stopwatch_tick_counter.sv | 138 +++++++++++++
 tb/tb_stopwatch_tick_counter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_tick_counter.sv
// rtl/stopwatch_tick_counter.sv - synchronised slow-clock tick detector driving a BCD up/down stopwatch counter
// Ticks are counted only in RUN; clear wins over start_stop and over a coincident tick.
module stopwatch_tick_counter #(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  tick_in,
  input  logic                  start_stop,
  input  logic                  clear,
  input  logic                  up_down,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  tick_seen,
  output logic                  rollover
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [2:0]             warm_cnt_q;
  logic                   warm;
  logic                   tick_edge;
  state_e                 state_q;
  logic [4*DIGITS-1:0]    count_q;
  logic [4*DIGITS-1:0]    count_d;
  logic                   wrap_d;
  logic                   running_q;
  logic                   tick_seen_q;
  logic                   rollover_q;

  // Warm-up masks the spurious edge seen when tick_in is already high at reset release.
  assign warm      = (warm_cnt_q == WARM_DONE);
  assign tick_edge = sync_q[SYNC_STAGES-1] & ~prev_q & warm;

  always_comb begin : bcd_step
    logic       carry;
    logic [3:0] digit;
    count_d = count_q;
    carry   = 1'b1;
    digit   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = count_q[4*i +: 4];
      if (carry) begin
        if (up_down) begin
          if (digit >= 4'd9) begin
            count_d[4*i +: 4] = 4'd0;
          end else begin
            count_d[4*i +: 4] = digit + 4'd1;
            carry             = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            count_d[4*i +: 4] = 4'd9;
          end else if (digit > 4'd9) begin
            count_d[4*i +: 4] = 4'd9;
            carry             = 1'b0;
          end else begin
            count_d[4*i +: 4] = digit - 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
    wrap_d = carry;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync_q      <= '0;
      prev_q      <= 1'b0;
      warm_cnt_q  <= 3'd0;
      state_q     <= ST_IDLE;
      count_q     <= '0;
      running_q   <= 1'b0;
      tick_seen_q <= 1'b0;
      rollover_q  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], tick_in};
      prev_q      <= sync_q[SYNC_STAGES-1];
      tick_seen_q <= tick_edge;
      rollover_q  <= 1'b0;
      if (warm_cnt_q != WARM_DONE) begin
        warm_cnt_q <= warm_cnt_q + 3'd1;
      end

      if (clear) begin
        state_q   <= ST_IDLE;
        count_q   <= '0;
        running_q <= 1'b0;
      end else begin
        // Counting looks at the state before this cycle's transition.
        if (tick_edge && (state_q == ST_RUN)) begin
          count_q    <= count_d;
          rollover_q <= wrap_d;
        end
        case (state_q)
          ST_IDLE: begin
            if (start_stop) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          ST_RUN: begin
            if (start_stop) begin
              state_q   <= ST_PAUSE;
              running_q <= 1'b0;
            end
          end
          ST_PAUSE: begin
            if (start_stop) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count     = count_q;
  assign running   = running_q;
  assign tick_seen = tick_seen_q;
  assign rollover  = rollover_q;

endmodule

// File: tb/tb_stopwatch_tick_counter.sv
// tb/tb_stopwatch_tick_counter.sv - directed and randomized checks of stopwatch_tick_counter against an integer reference model
module tb_stopwatch_tick_counter;

  localparam int D    = 4;
  localparam int S    = 2;
  localparam int MAXV = 10**D - 1;

  logic           clock      = 1'b0;
  logic           rst        = 1'b1;
  logic           tick_in    = 1'b0;
  logic           start_stop = 1'b0;
  logic           clear      = 1'b0;
  logic           up_down    = 1'b1;
  logic [4*D-1:0] count;
  logic           running;
  logic           tick_seen;
  logic           rollover;

  int checks   = 0;
  int failures = 0;
  int n        = 0;
  int seen_cnt = 0;
  bit hist[$];
  int m_val    = 0;
  int m_state  = 0;
  bit m_tick   = 1'b0;
  bit m_roll   = 1'b0;

  stopwatch_tick_counter #(.DIGITS(D), .SYNC_STAGES(S)) dut (
    .clock      (clock),
    .rst        (rst),
    .tick_in    (tick_in),
    .start_stop (start_stop),
    .clear      (clear),
    .up_down    (up_down),
    .count      (count),
    .running    (running),
    .tick_seen  (tick_seen),
    .rollover   (rollover)
  );

  always #5 clock = ~clock;

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int rem;
    r   = '0;
    rem = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: model evaluates at the edge from the pre-edge inputs, outputs are checked 1 ns later.
  task automatic step();
    bit ev;
    @(posedge clock);
    n++;
    hist.push_back(tick_in);
    ev = 1'b0;
    if (n >= S + 2) ev = hist[n-S-1] && !hist[n-S-2];
    m_tick = ev;
    m_roll = 1'b0;
    if (clear) begin
      m_state = 0;
      m_val   = 0;
    end else begin
      if (ev && m_state == 1) begin
        if (up_down) begin
          if (m_val == MAXV) begin m_val = 0; m_roll = 1'b1; end
          else m_val = m_val + 1;
        end else begin
          if (m_val == 0) begin m_val = MAXV; m_roll = 1'b1; end
          else m_val = m_val - 1;
        end
      end
      if (start_stop) m_state = (m_state == 1) ? 2 : 1;
    end
    #1;
    chk("count", 32'(count), 32'(to_bcd(m_val)));
    chk("running", 32'(running), 32'(m_state == 1));
    chk("tick_seen", 32'(tick_seen), 32'(m_tick));
    chk("rollover", 32'(rollover), 32'(m_roll));
    if (tick_seen === 1'b1) seen_cnt++;
  endtask

  task automatic apply_reset(input bit tick_level);
    rst = 1'b0;
    #1;
    n = 0;
    hist.delete();
    m_val   = 0;
    m_state = 0;
    m_tick  = 1'b0;
    m_roll  = 1'b0;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_tick_seen", 32'(tick_seen), 32'h0);
    chk("rst_rollover", 32'(rollover), 32'h0);
    tick_in = tick_level;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b1;
  endtask

  task automatic pulse_start();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Rising edge on tick_in; ss/clr land in the cycle the synchronised edge is live.
  task automatic do_tick(input bit ss, input bit clr);
    tick_in = 1'b1;
    repeat (S) step();
    start_stop = ss;
    clear      = clr;
    step();
    start_stop = 1'b0;
    clear      = 1'b0;
    tick_in    = 1'b0;
    repeat (S + 1) step();
  endtask

  initial begin
    int tick_left;

    #1;
    apply_reset(1'b1);
    seen_cnt = 0;
    pulse_start();
    repeat (10) step();
    chk("warm_count", 32'(count), 32'h0);
    chk("warm_seen", 32'(seen_cnt), 32'd0);
    chk("warm_running", 32'(running), 32'h1);
    tick_in = 1'b0;
    repeat (S + 1) step();

    pulse_clear();
    pulse_start();
    up_down  = 1'b1;
    seen_cnt = 0;
    repeat (12) do_tick(1'b0, 1'b0);
    chk("up12_count", 32'(count), 32'h0012);
    chk("up12_seen", 32'(seen_cnt), 32'd12);

    pulse_clear();
    pulse_start();
    up_down = 1'b0;
    do_tick(1'b0, 1'b0);
    chk("down_wrap", 32'(count), 32'h9999);
    do_tick(1'b0, 1'b0);
    chk("down_9998", 32'(count), 32'h9998);
    up_down = 1'b1;
    do_tick(1'b0, 1'b0);
    chk("up_9999", 32'(count), 32'h9999);
    do_tick(1'b0, 1'b0);
    chk("up_wrap", 32'(count), 32'h0000);

    pulse_clear();
    pulse_start();
    repeat (5) do_tick(1'b0, 1'b0);
    chk("pause_pre", 32'(count), 32'h0005);
    do_tick(1'b1, 1'b0);
    chk("pause_edge", 32'(count), 32'h0006);
    seen_cnt = 0;
    repeat (2) do_tick(1'b0, 1'b0);
    chk("pause_hold", 32'(count), 32'h0006);
    chk("pause_seen", 32'(seen_cnt), 32'd2);
    do_tick(1'b1, 1'b0);
    chk("resume_edge", 32'(count), 32'h0006);
    do_tick(1'b0, 1'b0);
    chk("resume_next", 32'(count), 32'h0007);

    pulse_clear();
    pulse_start();
    repeat (42) do_tick(1'b0, 1'b0);
    chk("pre_clear", 32'(count), 32'h0042);
    do_tick(1'b1, 1'b1);
    chk("clear_count", 32'(count), 32'h0000);
    chk("clear_running", 32'(running), 32'h0);
    pulse_start();
    repeat (3) do_tick(1'b0, 1'b0);
    tick_in = 1'b1;
    step();
    #2;
    apply_reset(1'b0);

    tick_left = S + 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 699) == 0) begin
        #2;
        apply_reset(tick_in);
        tick_left = S + 1;
      end
      start_stop = ($urandom_range(0, 9) == 0);
      clear      = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 39) == 0) up_down = ~up_down;
      step();
      start_stop = 1'b0;
      clear      = 1'b0;
      tick_left--;
      if (tick_left == 0) begin
        tick_in   = ~tick_in;
        tick_left = $urandom_range(S + 1, S + 4);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
